// File: rtl/uart_core_cfg.sv
// Parametrised full-duplex UART core.
// TX: valid/ready byte input, serialised as start, data LSB first, optional parity, stop bit(s).
// RX: 2-flop synchroniser, mid-bit sampling FSM, first-word fall-through FIFO with
//     per-entry parity/frame error flags and a sticky overrun flag.
//
// Handshakes (both directions): a transfer happens on a rising clock edge where
// valid and ready are both high. TX: ready is high only while the TX FSM is idle,
// and the byte on s_tx_data_i is latched on the accepting edge. RX: valid means the
// FIFO is not empty; the head entry is held stable until the consumer raises ready.
module uart_core_cfg #(
  parameter int CLK_DIV   = 10400,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 4
) (
  input  logic       s_clk_i,
  input  logic       s_resetn_i,
  input  logic       s_rxd_i,
  output logic       s_txd_o,
  input  logic       s_tx_valid_i,
  input  logic [7:0] s_tx_data_i,
  output logic       s_tx_ready_o,
  output logic       s_rx_valid_o,
  output logic [7:0] s_rx_data_o,
  output logic       s_rx_perr_o,
  output logic       s_rx_ferr_o,
  input  logic       s_rx_ready_i,
  output logic       s_rx_overrun_o,
  input  logic       s_clear_i,
  output logic       s_busy_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(RX_DEPTH);
  localparam int NW = PW + 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // ---------------------------------------------------------------- TX
  tx_state_e            tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_stop_q;
  logic                 txd_q;
  logic                 tx_par_bit;

  // Parity of the payload bits only; odd parity is the inverse of even.
  always_comb begin
    tx_par_bit = ^s_tx_data_i[DATA_BITS-1:0];
    if (PARITY == 2) tx_par_bit = ~tx_par_bit;
  end

  // TX FSM: each bit lasts CLK_DIV cycles; the line value is registered with the state.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (s_tx_valid_i) begin
            tx_state_q <= TX_START;
            tx_cnt_q   <= '0;
            tx_shift_q <= s_tx_data_i[DATA_BITS-1:0];
            tx_par_q   <= tx_par_bit;
            txd_q      <= 1'b0;
          end
        end
        default: begin
          if (tx_cnt_q != BIT_END) begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end else begin
            tx_cnt_q <= '0;
            case (tx_state_q)
              TX_START: begin
                tx_state_q <= TX_DATA;
                tx_bit_q   <= '0;
                txd_q      <= tx_shift_q[0];
              end
              TX_DATA: begin
                if (tx_bit_q == LAST_BIT) begin
                  if (PARITY != 0) begin
                    tx_state_q <= TX_PARITY;
                    txd_q      <= tx_par_q;
                  end else begin
                    tx_state_q <= TX_STOP;
                    tx_stop_q  <= 1'b0;
                    txd_q      <= 1'b1;
                  end
                end else begin
                  tx_bit_q   <= tx_bit_q + 1'b1;
                  tx_shift_q <= tx_shift_q >> 1;
                  txd_q      <= tx_shift_q[1];
                end
              end
              TX_PARITY: begin
                tx_state_q <= TX_STOP;
                tx_stop_q  <= 1'b0;
                txd_q      <= 1'b1;
              end
              TX_STOP: begin
                if (STOP_BITS == 2 && !tx_stop_q) tx_stop_q <= 1'b1;
                else                              tx_state_q <= TX_IDLE;
              end
              default: tx_state_q <= TX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_e            rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_perr_q;
  logic                 rx_meta_q;
  logic                 rx_sync_q;
  logic                 rx_par_exp;
  logic                 rx_push;
  logic [7:0]           rx_data_ext;
  logic [9:0]           rx_entry;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= s_rxd_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Expected parity bit, zero-extended payload and the FIFO entry built at the stop sample.
  always_comb begin
    rx_par_exp = ^rx_shift_q;
    if (PARITY == 2) rx_par_exp = ~rx_par_exp;
    rx_data_ext = '0;
    rx_data_ext[DATA_BITS-1:0] = rx_shift_q;
    rx_entry = {~rx_sync_q, rx_perr_q, rx_data_ext};
    rx_push  = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_END);
  end

  // RX FSM: start checked at half a bit, later bits one full bit period apart.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q != HALF_END) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
              rx_bit_q   <= '0;
              rx_perr_q  <= 1'b0;
            end
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != BIT_END) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            else                      rx_bit_q   <= rx_bit_q + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt_q != BIT_END) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q   <= '0;
            rx_perr_q  <= rx_sync_q ^ rx_par_exp;
            rx_state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != BIT_END) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end else begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [9:0]    mem_q [RX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q, count_d;
  logic          overrun_q;
  logic          fifo_full, pop, push_ok, ovr_evt;

  // A push into a full FIFO still lands if the head is popped on the same edge.
  always_comb begin
    fifo_full = (count_q == NW'(RX_DEPTH));
    pop       = (count_q != '0) && s_rx_ready_i;
    push_ok   = rx_push && (!fifo_full || pop);
    ovr_evt   = rx_push && fifo_full && !pop;
    count_d   = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; written only on an accepted push.
  always_ff @(posedge s_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_entry;
  end

  // Pointers, occupancy and the sticky overrun flag (set beats clear).
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (ovr_evt)        overrun_q <= 1'b1;
      else if (s_clear_i) overrun_q <= 1'b0;
    end
  end

  assign s_txd_o        = txd_q;
  assign s_tx_ready_o   = (tx_state_q == TX_IDLE);
  assign s_rx_valid_o   = (count_q != '0);
  assign s_rx_data_o    = mem_q[rd_ptr_q][7:0];
  assign s_rx_perr_o    = mem_q[rd_ptr_q][8];
  assign s_rx_ferr_o    = mem_q[rd_ptr_q][9];
  assign s_rx_overrun_o = overrun_q;
  assign s_busy_o       = (tx_state_q != TX_IDLE) || (rx_state_q != RX_IDLE);

endmodule
